// File: rtl/servant_spi_wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servant_spi_wb_master_pkg
// Description : Shared definitions for the SPI-to-Wishbone command master.
//               Holds the command opcodes, the FSM state encoding and the
//               width of the ack timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package servant_spi_wb_master_pkg;

    // Command opcodes presented on i_cmd_op
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CTRL  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // Master FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of the Wishbone ack timeout counter
    localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/servant_spi_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : servant_spi_wb_master
// Description : Wishbone master turning word-level commands from the SPI
//               register front-end into single Wishbone cycles. Keeps an
//               auto-incrementing word pointer and owns the CPU reset request.
//
// Ports
//   i_clk, i_rst      : wb_clk and synchronous active-high reset
//   i_cmd_*           : command handshake (valid/ready) and fields
//   o_rsp_*           : one-cycle response pulse with read data / timeout
//   o_wb_*, i_wb_*    : Wishbone master port towards the arbiter
//   o_cpu_reset       : CPU hold-in-reset request (set by CTRL commands)
//   o_busy            : high whenever the FSM is not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module servant_spi_wb_master
    import servant_spi_wb_master_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter bit RESET_HOLD = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic        i_cmd_inc,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,

    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,

    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,

    output logic        o_cpu_reset,
    output logic        o_busy
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    state_t             r_state;
    logic [31:0]        r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_wb_adr;
    logic [31:0]        r_wb_dat;
    logic [3:0]         r_wb_sel;
    logic               r_wb_we;
    logic               r_wb_cyc;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_dat;
    logic               r_rsp_err;
    logic               r_cpu_reset;

    logic [31:0]        w_eff_adr;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_unused_adr;

    // Byte-lane bits of the command address carry no meaning for word access
    assign w_unused_adr = ^i_cmd_adr[1:0];

    assign w_eff_adr = i_cmd_inc ? r_ptr : {i_cmd_adr[31:2], 2'b00};
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_wb_adr    <= '0;
            r_wb_dat    <= '0;
            r_wb_sel    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_cyc    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cpu_reset <= RESET_HOLD;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        case (i_cmd_op)
                            OP_WRITE, OP_READ: begin
                                r_wb_adr <= w_eff_adr;
                                r_wb_dat <= i_cmd_dat;
                                r_wb_sel <= (i_cmd_op == OP_READ) ? 4'hF : i_cmd_sel;
                                r_wb_we  <= (i_cmd_op == OP_WRITE);
                                r_wb_cyc <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= ST_BUS;
                            end
                            OP_CTRL: begin
                                r_cpu_reset <= i_cmd_dat[0];
                                r_rsp_dat   <= '0;
                                r_rsp_err   <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= ST_RESP;
                            end
                            default: begin
                                r_rsp_dat   <= '0;
                                r_rsp_err   <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= ST_RESP;
                            end
                        endcase
                    end
                end

                ST_BUS: begin
                    if (i_wb_ack) begin
                        r_wb_cyc    <= 1'b0;
                        r_rsp_dat   <= r_wb_we ? 32'h0 : i_wb_rdt;
                        r_rsp_err   <= 1'b0;
                        r_ptr       <= r_wb_adr + 32'd4;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_cnt_nxt == C_TIMEOUT) begin
                        // Abandon the access; the pointer still advances so a
                        // streamed transfer stays aligned with the host's view.
                        r_cnt       <= w_cnt_nxt;
                        r_wb_cyc    <= 1'b0;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_ptr       <= r_wb_adr + 32'd4;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_dat   = r_rsp_dat;
    assign o_rsp_err   = r_rsp_err;
    assign o_wb_adr    = r_wb_adr;
    assign o_wb_dat    = r_wb_dat;
    assign o_wb_sel    = r_wb_sel;
    assign o_wb_we     = r_wb_we;
    assign o_wb_cyc    = r_wb_cyc;
    assign o_cpu_reset = r_cpu_reset;

endmodule
`default_nettype wire

// File: tb/tb_servant_spi_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_spi_wb_master
// Description : Scoreboard bench for servant_spi_wb_master. Stimulus pushes
//               expected bus accesses and responses into queues; a monitor
//               pops and compares whenever the DUT starts a Wishbone cycle or
//               pulses a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_spi_wb_master;
    import servant_spi_wb_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic        cmd_inc = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        cpu_reset;
    logic        busy;

    always #5 clk = ~clk;

    servant_spi_wb_master #(
        .TIMEOUT    (4),
        .RESET_HOLD (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_inc   (cmd_inc),
        .i_cmd_adr   (cmd_adr),
        .i_cmd_dat   (cmd_dat),
        .i_cmd_sel   (cmd_sel),
        .o_rsp_valid (rsp_valid),
        .o_rsp_dat   (rsp_dat),
        .o_rsp_err   (rsp_err),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_cyc    (wb_cyc),
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack),
        .o_cpu_reset (cpu_reset),
        .o_busy      (busy)
    );

    // ---------------- Wishbone slave: RAM acking one cycle after cyc -------
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic        ack_r     = 1'b0;
    bit          ack_en    = 1'b1;
    logic        force_ack = 1'b0;

    assign wb_ack = ack_r | force_ack;
    assign wb_rdt = mem[wb_adr[11:2]];

    always @(posedge clk) begin
        ack_r <= wb_cyc & ~ack_r & ack_en;
        if (wb_cyc & ack_r & wb_we) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel[b]) mem[wb_adr[11:2]][8*b +: 8] <= wb_dat[8*b +: 8];
        end
    end

    // ---------------- Scoreboard ------------------------------------------
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          len;
    } bus_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int n_accepts  = 0;
    int n_sent     = 0;
    int n_rsp      = 0;
    int n_rsp_exp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: all sampling on the falling edge
    initial begin
        bus_t cur;
        int   cyc_len;
        logic prev_cyc;
        bit   have_cur;
        cyc_len  = 0;
        prev_cyc = 1'b0;
        have_cur = 1'b0;
        cur      = '{adr: '0, we: 1'b0, dat: '0, sel: '0, len: -1};
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready && !rst) n_accepts++;

            if (wb_cyc && !prev_cyc) begin
                cyc_len = 1;
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_cyc: got access at %08h expected none", wb_adr);
                end else begin
                    cur      = bus_q.pop_front();
                    have_cur = 1'b1;
                    check("wb_adr", wb_adr, cur.adr);
                    check("wb_we", {31'b0, wb_we}, {31'b0, cur.we});
                    check("wb_sel", {28'b0, wb_sel}, {28'b0, cur.sel});
                    if (cur.we) check("wb_dat", wb_dat, cur.dat);
                end
            end else if (wb_cyc) begin
                cyc_len++;
                if (have_cur) check("wb_adr_stable", wb_adr, cur.adr);
            end else if (prev_cyc && have_cur && cur.len > 0) begin
                check("cyc_len", cyc_len, cur.len);
            end
            prev_cyc = wb_cyc;

            if (rsp_valid) begin
                n_rsp++;
                check("ready_low_in_resp", {31'b0, cmd_ready}, 32'h0);
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got rsp dat=%08h expected none", rsp_dat);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_dat", rsp_dat, e.dat);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                end
            end
        end
    end

    // ---------------- Stimulus helpers (drive at posedge + 2) -------------
    task automatic issue(input logic [1:0] op, input logic inc, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input bit hold,
                         input bit exp_bus, input logic [31:0] exp_adr, input int exp_len,
                         input bit exp_rsp, input logic [31:0] exp_rdat, input logic exp_err);
        int t;
        t = 0;
        @(posedge clk); #2;
        while (!cmd_ready && t < 100) begin
            // Busy: hold valid (if requested) and scramble the fields
            cmd_valid = hold;
            cmd_op    = 2'($urandom);
            cmd_inc   = 1'($urandom);
            cmd_adr   = $urandom;
            cmd_dat   = $urandom;
            cmd_sel   = 4'($urandom);
            @(posedge clk); #2;
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_ready_timeout: got ready=0 expected ready within 100 cycles");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_inc   = inc;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        if (exp_bus)
            bus_q.push_back('{adr: exp_adr, we: (op == OP_WRITE), dat: dat,
                              sel: (op == OP_READ) ? 4'hF : sel, len: exp_len});
        if (exp_rsp) begin
            rsp_q.push_back('{dat: exp_rdat, err: exp_err});
            n_rsp_exp++;
        end
        n_sent++;
        @(posedge clk); #2;
        if (hold) begin
            cmd_op  = 2'($urandom);
            cmd_inc = 1'($urandom);
            cmd_adr = $urandom;
            cmd_dat = $urandom;
            cmd_sel = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || busy) && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d rsp pending expected 0", rsp_q.size());
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    // ---------------- Directed sequence -----------------------------------
    initial begin
        int t;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_cpu_reset", {31'b0, cpu_reset}, 32'h1);
        check("reset_cyc", {31'b0, wb_cyc}, 32'h0);
        check("reset_ready", {31'b0, cmd_ready}, 32'h1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_wb_adr", wb_adr, 32'h0);

        // Release CPU reset
        issue(OP_CTRL, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, -1, 1'b1, 32'h0, 1'b0);
        wait_idle();
        check("ctrl_cpu_reset_0", {31'b0, cpu_reset}, 32'h0);

        // Write then read back, low address bits ignored
        issue(OP_WRITE, 1'b0, 32'h100, 32'hA5A5_1234, 4'hF, 1'b0, 1'b1, 32'h100, 2, 1'b1, 32'h0, 1'b0);
        issue(OP_READ, 1'b0, 32'h102, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 32'h100, 2, 1'b1, 32'hA5A5_1234, 1'b0);
        wait_idle();
        check("busop_keeps_cpu_reset", {31'b0, cpu_reset}, 32'h0);

        // Auto-increment with valid held high throughout
        issue(OP_WRITE, 1'b0, 32'h200, 32'h1111_0200, 4'hF, 1'b1, 1'b1, 32'h200, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_WRITE, 1'b1, 32'hDEAD_0000, 32'h1111_0204, 4'hF, 1'b1, 1'b1, 32'h204, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_WRITE, 1'b1, 32'h0, 32'h1111_0208, 4'hF, 1'b1, 1'b1, 32'h208, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_WRITE, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b1, 32'h20C, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_READ, 1'b0, 32'h20C, 32'h0, 4'h0, 1'b1, 1'b1, 32'h20C, -1, 1'b1, 32'h0000_BEEF, 1'b0);
        issue(OP_READ, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h210, -1, 1'b1, 32'h0, 1'b0);
        wait_idle();

        // Pointer wrap, NOP leaves pointer alone
        issue(OP_WRITE, 1'b0, 32'hFFFF_FFFF, 32'hCAFE_0FFC, 4'hF, 1'b0, 1'b1, 32'hFFFF_FFFC, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_WRITE, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b1, 32'h0, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_NOP, 1'b0, 32'h800, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_WRITE, 1'b1, 32'h0, 32'h4444_4444, 4'hF, 1'b0, 1'b1, 32'h4, -1, 1'b1, 32'h0, 1'b0);
        issue(OP_READ, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, -1, 1'b1, 32'hCAFE_0FFC, 1'b0);
        wait_idle();

        // CTRL toggles the CPU reset request
        issue(OP_CTRL, 1'b0, 32'h0, 32'h1, 4'h0, 1'b0, 1'b0, 32'h0, -1, 1'b1, 32'h0, 1'b0);
        wait_idle();
        check("ctrl_cpu_reset_1", {31'b0, cpu_reset}, 32'h1);
        issue(OP_CTRL, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, -1, 1'b1, 32'h0, 1'b0);
        wait_idle();
        check("ctrl_cpu_reset_0b", {31'b0, cpu_reset}, 32'h0);

        // Timeout: no ack, cyc high for TIMEOUT=4 cycles
        ack_en = 1'b0;
        issue(OP_READ, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b1, 32'h300, 4, 1'b1, 32'h0, 1'b1);
        wait_idle();
        ack_en = 1'b1;
        issue(OP_READ, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h304, -1, 1'b1, 32'h0, 1'b0);
        wait_idle();

        // Reset in the middle of a bus cycle
        ack_en = 1'b0;
        issue(OP_WRITE, 1'b0, 32'h400, 32'h5555_5555, 4'hF, 1'b0, 1'b1, 32'h400, -1, 1'b0, 32'h0, 1'b0);
        t = 0;
        while (!wb_cyc && t < 20) begin
            @(posedge clk); #2;
            t++;
        end
        check("cyc_before_reset", {31'b0, wb_cyc}, 32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("reset_mid_bus_cyc", {31'b0, wb_cyc}, 32'h0);
        force_ack = 1'b1;
        @(posedge clk); #2;
        force_ack = 1'b0;
        @(posedge clk); #2;
        check("late_ack_cyc", {31'b0, wb_cyc}, 32'h0);
        check("late_ack_busy", {31'b0, busy}, 32'h0);
        check("reset_mid_bus_cpu_reset", {31'b0, cpu_reset}, 32'h1);
        ack_en = 1'b1;
        // Pointer back at 0 after reset
        issue(OP_READ, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, -1, 1'b1, 32'h0BAD_F00D, 1'b0);
        wait_idle();

        check("accept_count", n_accepts, n_sent);
        check("response_count", n_rsp, n_rsp_exp);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servant_spi_wb_master.md
Name: servant_spi_wb_master

Overview:
- Wishbone master that turns word-level commands from the SPI register front-end into single Wishbone cycles on the arbiter's SPI port.
- Used to load and inspect RAM over SPI, and owns the CPU hold-in-reset control.
- Sits between the SPI register block, upstream, and servant_arbiter's SPI master port, downstream.
- Runs entirely in the wb_clk domain. Command inputs arrive already synchronised.

Parameters:
- TIMEOUT, 255: maximum wait for i_wb_ack, in cycles, before the access is abandoned. Legal range 1..65535.
- RESET_HOLD, 1: reset value of o_cpu_reset (1 = CPU held in reset after system reset).

Ports:
- i_clk  in  1  wb_clk. Single clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_cmd_op  in  2  operation: 00 WRITE, 01 READ, 10 CTRL, 11 NOP.
- i_cmd_inc  in  1  1 = use internal pointer; 0 = load pointer from i_cmd_adr.
- i_cmd_adr  in  32  byte address; bits [1:0] ignored.
- i_cmd_dat  in  32  write data; for CTRL, bit 0 = cpu_reset.
- i_cmd_sel  in  4  byte enables for WRITE.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_dat  out  32  read data (0 for non-READ).
- o_rsp_err  out  1  access timed out.
- o_wb_adr  out  32  Wishbone address.
- o_wb_dat  out  32  Wishbone write data.
- o_wb_sel  out  4  Wishbone byte select.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_cyc  out  1  Wishbone cycle.
- i_wb_rdt  in  32  Wishbone read data.
- i_wb_ack  in  1  Wishbone acknowledge.
- o_cpu_reset  out  1  CPU reset request.
- o_busy  out  1  FSM not IDLE.

Behaviour:
- Reset values:
  - o_wb_cyc=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0.
  - o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0.
  - Pointer=0, timeout counter=0.
  - o_cpu_reset=RESET_HOLD, FSM=IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - o_cmd_ready=1; it is 0 in every other state.
  - On accept, the effective address is i_cmd_inc ? ptr : {i_cmd_adr[31:2],2'b00}.
  - WRITE/READ: register adr, dat, sel, we (sel forced to 4'hF for READ). Next cycle enters BUS with o_wb_cyc=1.
  - CTRL: o_cpu_reset <= i_cmd_dat[0]. Enter RESP. No bus cycle.
  - NOP: enter RESP with o_rsp_dat=0 and err=0. Pointer unchanged.
- BUS:
  - o_wb_cyc is held with adr/dat/sel/we stable until ack.
  - i_wb_ack=1 in the same cycle as cyc is legal (the arbiter RAM acks after 1 cycle).
  - On ack: o_wb_cyc <= 0; capture i_wb_rdt if READ, else 0; err=0; pointer <= effective address + 4; enter RESP.
  - The counter increments each BUS cycle without ack. When it reaches TIMEOUT: drop cyc, err=1, rsp_dat=0, pointer still advanced by 4, enter RESP.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. Minimum command-to-command spacing is 3 cycles for bus ops and 2 for CTRL/NOP.
- Pointer wraps 0xFFFF_FFFC -> 0x0000_0000.
- Counter is 16 bits and clears on entry to BUS.
- i_rst in any state returns to IDLE in the next cycle with all reset values. A Wishbone cycle in progress is dropped with no response; a late ack is ignored in IDLE.
- o_cpu_reset is driven only by CTRL and by reset; bus ops never change it.
- i_cmd_* are sampled only on accept; changes while busy are ignored.

Decomposition:
- Shared package holds:
  - op encodings OP_WRITE/OP_READ/OP_CTRL/OP_NOP;
  - FSM state encoding;
  - TIMEOUT counter width constant (16).
- No sub-module is needed. The timeout counter stays inline.

Test Plan:
- Reset: after i_rst, o_cpu_reset=1, o_wb_cyc=0, o_cmd_ready=1. Then CTRL dat=0 -> o_cpu_reset=0 and one o_rsp_valid with err=0.
- WRITE adr=0x100 dat=0xA5A5_1234 sel=4'hF, ack after 1 cycle -> single cyc with adr 0x100 and we=1. READ adr=0x100, rdt=0xA5A5_1234 -> o_rsp_dat=0xA5A5_1234.
- Auto-increment: WRITE inc=0 adr=0x200, then three WRITEs with inc=1 -> bus addresses 0x200, 0x204, 0x208, 0x20C. Pointer at 0xFFFF_FFFC wraps to 0.
- Timeout: TIMEOUT=4, ack never asserted -> cyc high for 4 cycles then low, o_rsp_err=1, o_rsp_dat=0. A following command proceeds normally.
- Reset mid-BUS: assert i_rst while cyc=1 -> cyc=0 next cycle, no o_rsp_valid, and an ack one cycle later is ignored.
- Handshake: i_cmd_valid held high continuously -> o_cmd_ready only in IDLE, exactly one accept per response, i_cmd_* changes while busy have no effect.
